// File: rtl/vram_writer.sv
// CPU-facing VRAM write port: a small register file with an auto-incrementing
// address feeds a write buffer that drains into VRAM through a ready/valid grant.
module vram_writer #(
    parameter int MEM_SIZE   = 7001,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        bus_cs,
    input  logic        bus_we,
    input  logic [2:0]  bus_addr,
    input  logic [7:0]  bus_wdata,
    output logic [7:0]  bus_rdata,
    output logic        mem_w_en,
    output logic [12:0] mem_w_addr,
    output logic [7:0]  mem_w_data,
    input  logic        mem_w_ready,
    output logic        busy
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [13:0] MEM_LIMIT = 14'(MEM_SIZE);

    logic [12:0]   addr;
    logic [7:0]    incr;
    logic          overflow;
    logic [12:0]   fifo_addr [FIFO_DEPTH];
    logic [7:0]    fifo_data [FIFO_DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] count;

    logic        full;
    logic        empty;
    logic        pop;
    logic        data_wr;
    logic        in_range;
    logic        push;
    logic [13:0] sum;
    logic [12:0] addr_step;
    logic [2:0]  count3;

    assign full     = (count == CW'(FIFO_DEPTH));
    assign empty    = (count == '0);
    assign pop      = !empty && mem_w_ready;
    assign data_wr  = bus_cs && bus_we && (bus_addr == 3'd2);
    assign in_range = ({1'b0, addr} < MEM_LIMIT);
    // A full buffer still accepts a push when the head retires in the same cycle.
    assign push     = data_wr && in_range && (!full || pop);
    assign sum      = {1'b0, addr} + {6'd0, incr};
    assign addr_step = 13'((sum >= MEM_LIMIT) ? (sum - MEM_LIMIT) : sum);
    assign count3   = 3'(count);

    assign mem_w_en   = !empty;
    assign mem_w_addr = fifo_addr[rd_ptr];
    assign mem_w_data = fifo_data[rd_ptr];
    assign busy       = full;

    always_comb begin
        bus_rdata = 8'h00;
        case (bus_addr)
            3'd0:    bus_rdata = addr[7:0];
            3'd1:    bus_rdata = {3'b000, addr[12:8]};
            3'd3:    bus_rdata = incr;
            3'd4:    bus_rdata = {overflow, full, empty, 2'b00, count3};
            default: bus_rdata = 8'h00;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            addr     <= '0;
            incr     <= 8'd1;
            overflow <= 1'b0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_addr[i] <= '0;
                fifo_data[i] <= '0;
            end
        end else begin
            if (bus_cs && bus_we) begin
                case (bus_addr)
                    3'd0: addr[7:0]  <= bus_wdata;
                    3'd1: addr[12:8] <= bus_wdata[4:0];
                    3'd2: begin
                        // Out-of-range address parks the pointer back at zero.
                        if (!in_range)
                            addr <= '0;
                        else if (push)
                            addr <= addr_step;
                        else
                            overflow <= 1'b1;
                    end
                    3'd3: incr <= bus_wdata;
                    3'd4: if (bus_wdata[0]) overflow <= 1'b0;
                    default: ;
                endcase
            end

            if (push) begin
                fifo_addr[wr_ptr] <= addr;
                fifo_data[wr_ptr] <= bus_wdata;
                wr_ptr            <= wr_ptr + PW'(1);
            end
            if (pop)
                rd_ptr <= rd_ptr + PW'(1);

            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_vram_writer.sv
// Directed bench for vram_writer: register access, address stepping and wrap,
// buffer overflow, simultaneous push/pop, and reset while writes are pending.
module tb_vram_writer;

    logic        clk = 1'b0;
    logic        reset;
    logic        bus_cs;
    logic        bus_we;
    logic [2:0]  bus_addr;
    logic [7:0]  bus_wdata;
    logic [7:0]  bus_rdata;
    logic        mem_w_en;
    logic [12:0] mem_w_addr;
    logic [7:0]  mem_w_data;
    logic        mem_w_ready;
    logic        busy;

    int checks = 0;
    int errors = 0;
    logic [20:0] log_q[$];

    vram_writer dut (
        .clk        (clk),
        .reset      (reset),
        .bus_cs     (bus_cs),
        .bus_we     (bus_we),
        .bus_addr   (bus_addr),
        .bus_wdata  (bus_wdata),
        .bus_rdata  (bus_rdata),
        .mem_w_en   (mem_w_en),
        .mem_w_addr (mem_w_addr),
        .mem_w_data (mem_w_data),
        .mem_w_ready(mem_w_ready),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Records each VRAM write that will complete at the coming rising edge.
    always @(negedge clk) begin
        #1;
        if (mem_w_en === 1'b1 && mem_w_ready === 1'b1 && reset === 1'b0)
            log_q.push_back({mem_w_addr, mem_w_data});
    end

    task automatic bus_write(input logic [2:0] a, input logic [7:0] d);
        @(negedge clk);
        bus_cs = 1'b1; bus_we = 1'b1; bus_addr = a; bus_wdata = d;
        @(negedge clk);
        bus_cs = 1'b0; bus_we = 1'b0;
        #2;
    endtask

    task automatic bus_read(input logic [2:0] a, output logic [7:0] d);
        bus_addr = a; bus_cs = 1'b1; bus_we = 1'b0;
        #1;
        d = bus_rdata;
        bus_cs = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
        #2;
    endtask

    task automatic wait_drain(input string name);
        int k = 0;
        while (mem_w_en !== 1'b0 && k < 50) begin
            @(negedge clk); #2;
            k++;
        end
        checks++;
        if (mem_w_en !== 1'b0) begin
            errors++;
            $display("[TB] FAIL %s drain timeout: mem_w_en=%b expected 0", name, mem_w_en);
        end
    endtask

    task automatic set_addr(input logic [12:0] a);
        bus_write(3'd0, a[7:0]);
        bus_write(3'd1, {3'b000, a[12:8]});
    endtask

    task automatic test_reset;
        logic [7:0] d;
        reset = 1'b1;
        idle(2);
        @(negedge clk); reset = 1'b0; #2;
        checks++; if (mem_w_en !== 1'b0) begin errors++; $display("[TB] FAIL reset_en: got %b expected 0", mem_w_en); end
        checks++; if (mem_w_addr !== 13'h0) begin errors++; $display("[TB] FAIL reset_waddr: got %h expected 0", mem_w_addr); end
        checks++; if (mem_w_data !== 8'h0) begin errors++; $display("[TB] FAIL reset_wdata: got %h expected 0", mem_w_data); end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
        bus_read(3'd4, d);
        checks++; if (d !== 8'h20) begin errors++; $display("[TB] FAIL reset_status: got %h expected 20", d); end
        bus_read(3'd3, d);
        checks++; if (d !== 8'h01) begin errors++; $display("[TB] FAIL reset_incr: got %h expected 01", d); end
        bus_read(3'd0, d);
        checks++; if (d !== 8'h00) begin errors++; $display("[TB] FAIL reset_addr_lo: got %h expected 00", d); end
        bus_read(3'd2, d);
        checks++; if (d !== 8'h00) begin errors++; $display("[TB] FAIL reset_data_read: got %h expected 00", d); end
    endtask

    task automatic test_basic;
        logic [7:0] d;
        mem_w_ready = 1'b1;
        set_addr(13'h0010);
        log_q.delete();
        bus_write(3'd2, 8'hAA);
        bus_write(3'd2, 8'hBB);
        wait_drain("basic");
        checks++; if (log_q.size() != 2) begin errors++; $display("[TB] FAIL basic_count: got %0d expected 2", log_q.size()); end
        if (log_q.size() == 2) begin
            checks++; if (log_q[0] !== {13'h0010, 8'hAA}) begin errors++; $display("[TB] FAIL basic_w0: got %h expected %h", log_q[0], {13'h0010, 8'hAA}); end
            checks++; if (log_q[1] !== {13'h0011, 8'hBB}) begin errors++; $display("[TB] FAIL basic_w1: got %h expected %h", log_q[1], {13'h0011, 8'hBB}); end
        end
        bus_read(3'd0, d);
        checks++; if (d !== 8'h12) begin errors++; $display("[TB] FAIL basic_addr_lo: got %h expected 12", d); end
    endtask

    task automatic test_latency_hold;
        mem_w_ready = 1'b0;
        set_addr(13'h0400);
        log_q.delete();
        bus_write(3'd2, 8'h99);
        checks++; if (mem_w_en !== 1'b1) begin errors++; $display("[TB] FAIL latency_en: got %b expected 1", mem_w_en); end
        checks++; if ({mem_w_addr, mem_w_data} !== {13'h0400, 8'h99}) begin errors++; $display("[TB] FAIL latency_head: got %h expected %h", {mem_w_addr, mem_w_data}, {13'h0400, 8'h99}); end
        bus_write(3'd0, 8'h33);
        idle(2);
        checks++; if ({mem_w_en, mem_w_addr, mem_w_data} !== {1'b1, 13'h0400, 8'h99}) begin errors++; $display("[TB] FAIL hold_stable: got %h expected %h", {mem_w_en, mem_w_addr, mem_w_data}, {1'b1, 13'h0400, 8'h99}); end
        @(negedge clk); mem_w_ready = 1'b1;
        idle(1);
        checks++; if (mem_w_en !== 1'b0) begin errors++; $display("[TB] FAIL complete_en: got %b expected 0", mem_w_en); end
        checks++; if (log_q.size() != 1) begin errors++; $display("[TB] FAIL complete_count: got %0d expected 1", log_q.size()); end
    endtask

    task automatic test_wrap;
        logic [7:0] d;
        mem_w_ready = 1'b1;
        set_addr(13'd7000);
        bus_write(3'd3, 8'd2);
        log_q.delete();
        bus_write(3'd2, 8'h55);
        wait_drain("wrap");
        checks++; if (log_q.size() != 1 || log_q[0] !== {13'd7000, 8'h55}) begin errors++; $display("[TB] FAIL wrap_write: got n=%0d %h expected %h", log_q.size(), (log_q.size() > 0) ? log_q[0] : 21'h0, {13'd7000, 8'h55}); end
        bus_read(3'd0, d);
        checks++; if (d !== 8'h01) begin errors++; $display("[TB] FAIL wrap_addr_lo: got %h expected 01", d); end
        bus_read(3'd1, d);
        checks++; if (d !== 8'h00) begin errors++; $display("[TB] FAIL wrap_addr_hi: got %h expected 00", d); end
    endtask

    task automatic test_overflow;
        logic [7:0] d;
        mem_w_ready = 1'b0;
        bus_write(3'd3, 8'd1);
        set_addr(13'h0100);
        log_q.delete();
        for (int i = 0; i < 4; i++) bus_write(3'd2, 8'h10 + 8'(i));
        checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL ovf_busy: got %b expected 1", busy); end
        bus_write(3'd2, 8'h14);
        bus_read(3'd4, d);
        checks++; if (d !== 8'hC4) begin errors++; $display("[TB] FAIL ovf_status: got %h expected C4", d); end
        bus_read(3'd0, d);
        checks++; if (d !== 8'h04) begin errors++; $display("[TB] FAIL ovf_addr_lo: got %h expected 04", d); end
        @(negedge clk); mem_w_ready = 1'b1;
        wait_drain("ovf");
        checks++; if (log_q.size() != 4) begin errors++; $display("[TB] FAIL ovf_count: got %0d expected 4", log_q.size()); end
        for (int i = 0; i < 4 && i < log_q.size(); i++) begin
            checks++;
            if (log_q[i] !== {13'h0100 + 13'(i), 8'h10 + 8'(i)}) begin errors++; $display("[TB] FAIL ovf_order%0d: got %h expected %h", i, log_q[i], {13'h0100 + 13'(i), 8'h10 + 8'(i)}); end
        end
        bus_read(3'd4, d);
        checks++; if (d !== 8'hA0) begin errors++; $display("[TB] FAIL ovf_sticky: got %h expected A0", d); end
        bus_write(3'd4, 8'h01);
        bus_read(3'd4, d);
        checks++; if (d !== 8'h20) begin errors++; $display("[TB] FAIL ovf_clear: got %h expected 20", d); end
    endtask

    task automatic test_full_push_pop;
        logic [7:0] d;
        mem_w_ready = 1'b0;
        set_addr(13'h0200);
        log_q.delete();
        for (int i = 0; i < 4; i++) bus_write(3'd2, 8'h20 + 8'(i));
        @(negedge clk);
        mem_w_ready = 1'b1; bus_cs = 1'b1; bus_we = 1'b1; bus_addr = 3'd2; bus_wdata = 8'h24;
        @(negedge clk);
        mem_w_ready = 1'b0; bus_cs = 1'b0; bus_we = 1'b0;
        #2;
        bus_read(3'd4, d);
        checks++; if (d !== 8'h44) begin errors++; $display("[TB] FAIL pp_status: got %h expected 44", d); end
        bus_read(3'd0, d);
        checks++; if (d !== 8'h05) begin errors++; $display("[TB] FAIL pp_addr_lo: got %h expected 05", d); end
        @(negedge clk); mem_w_ready = 1'b1;
        wait_drain("pp");
        checks++; if (log_q.size() != 5) begin errors++; $display("[TB] FAIL pp_count: got %0d expected 5", log_q.size()); end
        for (int i = 0; i < 5 && i < log_q.size(); i++) begin
            checks++;
            if (log_q[i] !== {13'h0200 + 13'(i), 8'h20 + 8'(i)}) begin errors++; $display("[TB] FAIL pp_order%0d: got %h expected %h", i, log_q[i], {13'h0200 + 13'(i), 8'h20 + 8'(i)}); end
        end
    endtask

    task automatic test_out_of_range;
        logic [7:0] d;
        mem_w_ready = 1'b1;
        set_addr(13'h1FFF);
        log_q.delete();
        bus_write(3'd2, 8'h77);
        idle(3);
        checks++; if (log_q.size() != 0) begin errors++; $display("[TB] FAIL oor_writes: got %0d expected 0", log_q.size()); end
        bus_read(3'd0, d);
        checks++; if (d !== 8'h00) begin errors++; $display("[TB] FAIL oor_addr_lo: got %h expected 00", d); end
        bus_read(3'd1, d);
        checks++; if (d !== 8'h00) begin errors++; $display("[TB] FAIL oor_addr_hi: got %h expected 00", d); end
    endtask

    task automatic test_incr_zero;
        mem_w_ready = 1'b1;
        bus_write(3'd3, 8'd0);
        set_addr(13'h0050);
        log_q.delete();
        for (int i = 1; i <= 3; i++) bus_write(3'd2, 8'(i));
        wait_drain("incr0");
        checks++; if (log_q.size() != 3) begin errors++; $display("[TB] FAIL incr0_count: got %0d expected 3", log_q.size()); end
        for (int i = 0; i < 3 && i < log_q.size(); i++) begin
            checks++;
            if (log_q[i] !== {13'h0050, 8'(i + 1)}) begin errors++; $display("[TB] FAIL incr0_w%0d: got %h expected %h", i, log_q[i], {13'h0050, 8'(i + 1)}); end
        end
    endtask

    task automatic test_reset_pending;
        logic [7:0] d;
        mem_w_ready = 1'b0;
        bus_write(3'd3, 8'd5);
        set_addr(13'h0300);
        log_q.delete();
        for (int i = 0; i < 3; i++) bus_write(3'd2, 8'h30 + 8'(i));
        bus_read(3'd4, d);
        checks++; if (d !== 8'h03) begin errors++; $display("[TB] FAIL rp_status_pre: got %h expected 03", d); end
        @(negedge clk); reset = 1'b1;
        @(negedge clk); reset = 1'b0; #2;
        checks++; if (mem_w_en !== 1'b0) begin errors++; $display("[TB] FAIL rp_en: got %b expected 0", mem_w_en); end
        bus_read(3'd4, d);
        checks++; if (d !== 8'h20) begin errors++; $display("[TB] FAIL rp_status: got %h expected 20", d); end
        bus_read(3'd3, d);
        checks++; if (d !== 8'h01) begin errors++; $display("[TB] FAIL rp_incr: got %h expected 01", d); end
        @(negedge clk); mem_w_ready = 1'b1;
        idle(3);
        checks++; if (log_q.size() != 0) begin errors++; $display("[TB] FAIL rp_writes: got %0d expected 0", log_q.size()); end
    endtask

    initial begin
        reset = 1'b1; bus_cs = 1'b0; bus_we = 1'b0; bus_addr = 3'd0; bus_wdata = 8'h00; mem_w_ready = 1'b0;
        $display("[TB] starting vram_writer bench");
        test_reset();
        test_basic();
        test_latency_hold();
        test_wrap();
        test_overflow();
        test_full_push_pop();
        test_out_of_range();
        test_incr_zero();
        test_reset_pending();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/vram_writer.md
VRAM_WRITER -- requirements
Module: vram_writer

Interface
REQ-001 SHALL have parameter MEM_SIZE, default 7001: number of writable VRAM bytes, valid addresses 0..MEM_SIZE-1.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4: write-buffer entries, power of two.
REQ-003 SHALL use one clock and a synchronous, active-high reset: clk  input  1  sole clock, all logic on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 bus_cs  input  1  CPU register access strobe, one cycle per access.
REQ-006 bus_we  input  1  1 = write, 0 = read; qualified by bus_cs.
REQ-007 bus_addr  input  3  register select.
REQ-008 bus_wdata  input  8  CPU write data.
REQ-009 bus_rdata  output  8  register read data, combinational from bus_addr.
REQ-010 mem_w_en  output  1  VRAM write request, registered.
REQ-011 mem_w_addr  output  13  VRAM write address.
REQ-012 mem_w_data  output  8  VRAM write data.
REQ-013 mem_w_ready  input  1  arbiter grant; a write completes on a cycle with mem_w_en=1 and mem_w_ready=1.
REQ-014 busy  output  1  buffer full (count == FIFO_DEPTH).

Function
REQ-015 Register map SHALL be: 0 ADDR_LO (r/w, addr[7:0]); 1 ADDR_HI (r/w, addr[12:8], bits 7:5 read 0); 2 DATA (write-only, reads 0); 3 INCR (r/w, 8-bit step); 4 STATUS (read {overflow, full, empty, 2'b0, count[2:0]}; write with bit0=1 clears overflow); 5-7 read 0, writes ignored.
REQ-016 A DATA write with the buffer not full and addr < MEM_SIZE SHALL push {addr, bus_wdata} and update addr to addr+INCR, minus MEM_SIZE when the sum >= MEM_SIZE.
REQ-017 A DATA write with addr >= MEM_SIZE SHALL push nothing and set addr to 0.
REQ-018 A DATA write with the buffer full and no pop in the same cycle SHALL push nothing, leave addr unchanged, and set sticky overflow.
REQ-019 A pop and a push in the same cycle SHALL both take effect, including when the buffer is full; count is unchanged.
REQ-020 The buffer head SHALL drive mem_w_addr and mem_w_data, with mem_w_en = !empty, all from registers.
REQ-021 Latency: a DATA write at edge N into an empty buffer SHALL present mem_w_en=1 after edge N; the write completes at the first edge with mem_w_ready=1.
REQ-022 mem_w_en, mem_w_addr and mem_w_data SHALL hold stable while mem_w_en=1 and mem_w_ready=0.
REQ-023 Entries SHALL reach VRAM in push order; none are dropped or duplicated.
REQ-024 With INCR=0, repeated DATA writes SHALL target the same address.
REQ-025 ADDR_LO and ADDR_HI writes SHALL take effect at the next edge and SHALL NOT alter buffered entries.
REQ-026 A bus write to a register and a DATA-driven address update cannot coincide, because there is one access per cycle.

Reset
REQ-027 On reset=1 at a clock edge: addr=0, INCR=1, overflow=0, buffer emptied (count=0).
REQ-028 Outputs after reset: mem_w_en=0, mem_w_addr=0, mem_w_data=0, busy=0.
REQ-029 Reset asserted while a write is pending SHALL discard all buffered entries; no mem_w_en is asserted in the following cycle.

Verification
REQ-030 Set addr=0x0010, INCR=1, mem_w_ready=1, write DATA 0xAA, 0xBB -> VRAM writes (0x0010,0xAA) then (0x0011,0xBB); ADDR_LO reads 0x12.
REQ-031 Set addr=7000, INCR=2, write DATA 0x55 -> VRAM write (7000,0x55); addr reads 1.
REQ-032 Set mem_w_ready=0, write DATA 5 times -> busy=1 after 4; 5th dropped; STATUS reads 0x84|0x40 (overflow, full, count 4); release ready -> exactly 4 ordered writes; write STATUS 0x01 -> overflow=0.
REQ-033 With buffer full, mem_w_ready=1 and a DATA write in the same cycle -> push accepted, count stays 4, no overflow.
REQ-034 Set addr=0x1FFF (>= MEM_SIZE), write DATA -> no VRAM write; addr reads 0.
REQ-035 Fill 3 entries with mem_w_ready=0, pulse reset -> mem_w_en=0 next cycle; STATUS reads 0x20 (empty); INCR reads 1.
